// File: rtl/mvu_csr_apb_master_if.sv
// APB bus bundle between the MVU CSR master and the MVU array's CSR slave.
// The master modport drives the request phase; the slave modport drives completion.
interface mvu_csr_apb_master_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
);
   logic              apb_psel;
   logic              apb_penable;
   logic              apb_pwrite;
   logic [ADDR_W-1:0] apb_paddr;
   logic [DATA_W-1:0] apb_pwdata;
   logic [DATA_W-1:0] apb_prdata;
   logic              apb_pready;
   logic              apb_pslverr;

   modport master (
      output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
      input  apb_prdata, apb_pready, apb_pslverr
   );

   modport slave (
      input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
      output apb_prdata, apb_pready, apb_pslverr
   );
endinterface

// File: rtl/mvu_csr_apb_master.sv
// Queued APB master: buffers CSR requests in a FIFO and issues them in order
// as APB transfers, with wait-state support and an ACCESS-phase timeout.
module mvu_csr_apb_master #(
   parameter int BMVUA          = 3,
   parameter int APB_ADDR_WIDTH = BMVUA + 12,
   parameter int APB_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT        = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [BMVUA-1:0]          req_mvu_id,
   input  logic [11:0]               req_csr,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata,
   output logic                      rsp_valid,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
   output logic                      rsp_err,
   output logic                      busy,
   mvu_csr_apb_master_if.master      apb
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] WAIT_ONE = CW'(1);
   localparam logic [CW-1:0] TO_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   typedef struct packed {
      logic                      write;
      logic [BMVUA-1:0]          mvu_id;
      logic [11:0]               csr;
      logic [APB_DATA_WIDTH-1:0] wdata;
   } req_t;

   state_e                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      rsp_err_q, rsp_err_d;
   logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   req_t                      mem_q [FIFO_DEPTH];
   req_t                      mem_d [FIFO_DEPTH];
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]               count_q, count_d;

   req_t                      head, req_in;
   logic                      empty, push, pop, done;

   assign empty     = (count_q == '0);
   assign req_ready = (count_q != FULL_CNT);
   assign busy      = !empty || (state_q != IDLE);
   assign head      = mem_q[rd_ptr_q];
   assign req_in    = {req_write, req_mvu_id, req_csr, req_wdata};
   assign push      = req_valid && req_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      pop         = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         IDLE:  pop = !empty;
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: begin
            if (apb.apb_pready) begin
               done      = 1'b1;
               rsp_err_d = apb.apb_pslverr;
               if (!pwrite_q && !apb.apb_pslverr) rsp_rdata_d = apb.apb_prdata;
            end else begin
               cnt_d = cnt_q + WAIT_ONE;
               // Abort on the TIMEOUT-th ACCESS cycle that saw no pready.
               if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                  done      = 1'b1;
                  rsp_err_d = 1'b1;
               end
            end
            rsp_valid_d = done;
            if (done) begin
               pop     = !empty;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         state_d  = SETUP;
         pwrite_d = head.write;
         paddr_d  = {head.mvu_id, head.csr};
         pwdata_d = head.write ? head.wdata : '0;
      end else if (state_d == IDLE) begin
         pwrite_d = 1'b0;
         paddr_d  = '0;
         pwdata_d = '0;
      end

      psel_d    = (state_d != IDLE);
      penable_d = (state_d == ACCESS);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = req_in;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mem_q       <= mem_d;
      end
   end

   assign apb.apb_psel    = psel_q;
   assign apb.apb_penable = penable_q;
   assign apb.apb_pwrite  = pwrite_q;
   assign apb.apb_paddr   = paddr_q;
   assign apb.apb_pwdata  = pwdata_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_err         = rsp_err_q;
   assign rsp_rdata       = rsp_rdata_q;

endmodule

// File: tb/tb_mvu_csr_apb_master.sv
// Bench for mvu_csr_apb_master: directed timing scenarios plus random traffic,
// scored against a transaction-level model of the request queue and APB slave.
module tb_mvu_csr_apb_master;
   localparam int BMVUA = 3;
   localparam int AW = BMVUA + 12;
   localparam int DW = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT = 16;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             req_valid, req_ready, req_write;
   logic [BMVUA-1:0] req_mvu_id;
   logic [11:0]      req_csr;
   logic [DW-1:0]    req_wdata;
   logic             rsp_valid, rsp_err, busy;
   logic [DW-1:0]    rsp_rdata;

   mvu_csr_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

   mvu_csr_apb_master #(
      .BMVUA(BMVUA), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
      .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_mvu_id(req_mvu_id), .req_csr(req_csr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .apb(apb)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic             w;
      logic [BMVUA-1:0] id;
      logic [11:0]      csr;
      logic [DW-1:0]    d;
   } req_s;
   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
      int            due;
   } rsp_s;

   req_s acc_q[$];
   rsp_s rq[$];

   bit            lg_psel [MAXC];
   bit            lg_pen  [MAXC];
   bit            lg_rsp  [MAXC];
   bit            lg_busy [MAXC];
   bit            lg_rdy  [MAXC];
   bit            lg_err  [MAXC];
   logic [AW-1:0] lg_addr [MAXC];
   logic [DW-1:0] lg_rdata[MAXC];

   // Slave behaviour knobs
   bit            s_rand = 0, s_hang = 0, s_err = 0;
   int            s_waits = 0;
   logic [DW-1:0] s_data = '0;

   // APB slave: picks wait states in SETUP, answers during ACCESS.
   initial begin
      int w, an;
      bit e;
      w = 0; an = 0; e = 0;
      apb.apb_pready = 1'b0; apb.apb_pslverr = 1'b0; apb.apb_prdata = '0;
      forever begin
         @(posedge clk); #2;
         apb.apb_pready = 1'b0; apb.apb_pslverr = 1'b0; apb.apb_prdata = '0;
         if (apb.apb_psel && !apb.apb_penable) begin
            an = 0;
            if (s_rand) begin
               w = ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 3));
               e = ($urandom_range(0, 3) == 0);
            end else begin
               w = s_waits;
               e = s_err;
            end
         end else if (apb.apb_psel && apb.apb_penable) begin
            if (!s_hang && an == w) begin
               apb.apb_pready  = 1'b1;
               apb.apb_pslverr = e;
               apb.apb_prdata  = s_rand ? DW'($urandom) : s_data;
            end
            an++;
         end
      end
   end

   // Transaction-level model: accepted requests go out in order, one response each.
   initial begin
      req_s cur;
      rsp_s r;
      int   wcnt, occ;
      bit   prev_setup, prev_done, prev_hold;
      cur = '{w: 1'b0, id: '0, csr: '0, d: '0};
      wcnt = 0; prev_setup = 0; prev_done = 0; prev_hold = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc_q.delete(); rq.delete();
            prev_setup = 0; prev_done = 0; prev_hold = 0;
         end else begin
            if (cyc < MAXC) begin
               lg_psel[cyc] = apb.apb_psel;  lg_pen[cyc] = apb.apb_penable;
               lg_rsp[cyc] = rsp_valid;      lg_busy[cyc] = busy;
               lg_rdy[cyc] = req_ready;      lg_err[cyc] = rsp_err;
               lg_addr[cyc] = apb.apb_paddr; lg_rdata[cyc] = rsp_rdata;
            end
            occ = acc_q.size() - ((apb.apb_psel && !apb.apb_penable) ? 1 : 0);
            chk("req_ready", 64'(req_ready), 64'(occ < FIFO_DEPTH));
            chk("busy", 64'(busy), 64'(apb.apb_psel || acc_q.size() != 0));
            if (prev_setup || prev_hold)
               chk("access_follows", 64'({apb.apb_psel, apb.apb_penable}), 64'(2'b11));
            if (prev_done) chk("penable_drop", 64'(apb.apb_penable), 64'(0));
            prev_setup = 0; prev_done = 0; prev_hold = 0;
            if (!apb.apb_psel) begin
               chk("idle_bus", 64'({apb.apb_penable, apb.apb_pwrite, apb.apb_paddr, apb.apb_pwdata}), 64'(0));
            end else if (!apb.apb_penable) begin
               if (acc_q.size() == 0) chk("spurious_setup", 64'(apb.apb_psel), 64'(0));
               else begin
                  cur = acc_q.pop_front();
                  wcnt = 0;
                  prev_setup = 1;
                  chk("setup_bus", 64'({apb.apb_pwrite, apb.apb_paddr, apb.apb_pwdata}),
                      64'({cur.w, cur.id, cur.csr, cur.w ? cur.d : 32'h0}));
               end
            end else begin
               chk("access_bus", 64'({apb.apb_pwrite, apb.apb_paddr, apb.apb_pwdata}),
                   64'({cur.w, cur.id, cur.csr, cur.w ? cur.d : 32'h0}));
               wcnt++;
               if (apb.apb_pready) begin
                  r.err = apb.apb_pslverr;
                  r.rdata = (!cur.w && !apb.apb_pslverr) ? apb.apb_prdata : '0;
                  r.due = cyc + 1;
                  rq.push_back(r);
                  prev_done = 1;
               end else if (TIMEOUT != 0 && wcnt == TIMEOUT) begin
                  r.err = 1'b1; r.rdata = '0; r.due = cyc + 1;
                  rq.push_back(r);
                  prev_done = 1;
               end else prev_hold = 1;
            end
            if (rq.size() != 0 && rq[0].due == cyc) begin
               r = rq.pop_front();
               chk("rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, r.err, r.rdata}));
            end else if (rsp_valid) chk("rsp_spurious", 64'(rsp_valid), 64'(0));
            if (req_valid && req_ready)
               acc_q.push_back('{w: req_write, id: req_mvu_id, csr: req_csr, d: req_wdata});
         end
      end
   end

   // Called at posedge+1; returns the cycle index that starts at the accepting edge.
   task automatic push(input logic w, input logic [BMVUA-1:0] id, input logic [11:0] csr,
                       input logic [DW-1:0] d, output int acc);
      logic r;
      r = 1'b0;
      acc = -1;
      req_valid = 1'b1; req_write = w; req_mvu_id = id; req_csr = csr; req_wdata = d;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); r = req_ready;
         @(posedge clk); #1;
         if (r) begin acc = cyc; break; end
      end
      req_valid = 1'b0;
      if (acc < 0) chk("push_timeout", 64'(r), 64'(1));
   endtask

   task automatic wait_idle(input int lim);
      logic b;
      b = 1'b1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk); b = busy;
         if (!b) break;
      end
      if (b) chk("drain_timeout", 64'(b), 64'(0));
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   function automatic logic [15:0] seq(input int which, input int a, input int n);
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < n; k++)
         case (which)
            0: v[k] = lg_psel[a+k];
            1: v[k] = lg_pen[a+k];
            2: v[k] = lg_rsp[a+k];
            default: v[k] = lg_busy[a+k];
         endcase
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, b, a1, a5, a6, sum;
      req_valid = 1'b0; req_write = 1'b0; req_mvu_id = '0; req_csr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_bus", 64'({apb.apb_psel, apb.apb_penable, apb.apb_pwrite, apb.apb_paddr, apb.apb_pwdata}), 64'(0));
      chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
      chk("rst_rdy_busy", 64'({req_ready, busy}), 64'(2'b10));
      @(posedge clk); #4 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single zero-wait write
      push(1'b1, 3'd2, 12'h010, 32'hDEAD_BEEF, a);
      wait_idle(50);
      chk("t1_psel", 64'(seq(0, a, 5)), 64'(5'b00110));
      chk("t1_pen", 64'(seq(1, a, 5)), 64'(5'b00100));
      chk("t1_rsp", 64'(seq(2, a, 5)), 64'(5'b01000));
      chk("t1_addr", 64'(lg_addr[a+1]), 64'(15'h2010));
      chk("t1_err", 64'(lg_err[a+3]), 64'(0));

      // Three back-to-back writes
      push(1'b1, 3'd1, 12'h100, 32'h1111_0001, a);
      push(1'b1, 3'd3, 12'h104, 32'h1111_0002, b);
      push(1'b1, 3'd5, 12'h108, 32'h1111_0003, b);
      wait_idle(50);
      chk("t2_psel", 64'(seq(0, a, 8)), 64'(8'b0111_1110));
      chk("t2_pen", 64'(seq(1, a, 8)), 64'(8'b0101_0100));
      chk("t2_rsp", 64'(seq(2, a, 8)), 64'(8'b1010_1000));
      chk("t2_busy", 64'(seq(3, a, 8)), 64'(8'b0111_1111));

      // Reads with wait states, then a slave error
      s_waits = 3; s_data = 32'h0000_1234;
      push(1'b0, 3'd1, 12'h020, 32'hFFFF_FFFF, a);
      wait_idle(50);
      chk("t4_pen", 64'(seq(1, a, 7)), 64'(7'b011_1100));
      chk("t4_rsp", 64'({lg_rsp[a+6], lg_err[a+6], lg_rdata[a+6]}), 64'({2'b10, 32'h1234}));
      s_waits = 0; s_err = 1'b1;
      push(1'b0, 3'd1, 12'h020, 32'h0, a);
      wait_idle(50);
      chk("t4_slverr", 64'({lg_rsp[a+3], lg_err[a+3], lg_rdata[a+3]}), 64'({2'b11, 32'h0}));
      s_err = 1'b0;

      // Stalled slave: FIFO fills, first transfer times out
      s_hang = 1'b1;
      push(1'b1, 3'd0, 12'h001, 32'hA0, a1);
      for (int i = 0; i < 4; i++) push(1'b0, 3'(i), 12'(i + 2), 32'hA0 + 32'(i), a5);
      push(1'b1, 3'd7, 12'hFFF, 32'hA9, a6);
      chk("t3_fill", 64'(a5), 64'(a1 + 4));
      chk("t3_full", 64'(lg_rdy[a5]), 64'(0));
      chk("t3_stall", 64'(a6), 64'(a1 + 3 + TIMEOUT));
      sum = 0;
      for (int k = a1 + 2; k < a1 + 2 + TIMEOUT; k++) sum += int'(lg_pen[k]);
      chk("t3_access_len", 64'(sum), 64'(TIMEOUT));
      chk("t3_abort", 64'({lg_psel[a1+2+TIMEOUT], lg_pen[a1+2+TIMEOUT], lg_rsp[a1+2+TIMEOUT],
                           lg_err[a1+2+TIMEOUT]}), 64'(4'b1011));
      wait_idle(400);
      s_hang = 1'b0;

      // Reset in the middle of ACCESS
      s_hang = 1'b1;
      push(1'b1, 3'd4, 12'h0C0, 32'h55, a);
      push(1'b0, 3'd4, 12'h0C4, 32'h0, a);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (apb.apb_penable) break;
      end
      @(posedge clk); #3 rst_n = 1'b0;
      #1 chk("rst_async", 64'({apb.apb_psel, apb.apb_penable, rsp_valid, req_ready, busy}), 64'(5'b00010));
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      s_hang = 1'b0;
      @(negedge clk);
      chk("rst_after", 64'({req_ready, busy}), 64'(2'b10));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_rsp", 64'({rsp_valid, apb.apb_psel}), 64'(0));
      end
      @(posedge clk); #1;

      // Random traffic against the scoreboard
      s_rand = 1'b1;
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         push(1'($urandom), 3'($urandom), 12'($urandom), 32'($urandom), a);
      end
      wait_idle(2000);
      chk("sb_left", 64'(acc_q.size() + rq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mvu_csr_apb_master.md
# mvu_csr_apb_master

Queued APB master that turns CSR access requests from the controller side into APB transfers addressed to the MVU array's CSR slave. It sits directly upstream of that slave: its APB outputs drive psel/penable/pwrite/paddr/pwdata, and it consumes pready/prdata/pslverr. Requests are buffered in a small FIFO and issued strictly in order, with back-to-back transfers, wait-state support and a programmable access timeout.

## Interface
- BMVUA, 3, MVU index width; selects paddr[APB_ADDR_WIDTH-1:12]
- APB_ADDR_WIDTH, BMVUA+12, APB address width
- APB_DATA_WIDTH, 32, APB data width
- FIFO_DEPTH, 4, request FIFO entries; power of two, ≥2
- TIMEOUT, 16, max ACCESS cycles without pready; 0 disables timeout
---
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept (= not full)
- req_write  in  1  1 = write, 0 = read
- req_mvu_id  in  BMVUA  target MVU
- req_csr  in  12  CSR address
- req_wdata  in  APB_DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse per completed/aborted transfer
- rsp_rdata  out  APB_DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  valid with rsp_valid: pslverr or timeout
- busy  out  1  FIFO non-empty or FSM not IDLE
- apb_psel, apb_penable, apb_pwrite  out  1 each  APB control
- apb_paddr  out  APB_ADDR_WIDTH  {mvu_id, csr}
- apb_pwdata  out  APB_DATA_WIDTH  write data; 0 on reads
- apb_prdata  in  APB_DATA_WIDTH  read data
- apb_pready, apb_pslverr  in  1 each  slave completion, error

## Operation
- Accept: req_valid && req_ready pushes {write, mvu_id, csr, wdata}; no push when full; no bypass path.
- FSM states IDLE, SETUP, ACCESS.
- IDLE: FIFO non-empty → pop head into address/data/control regs, go SETUP.
- SETUP: psel=1, penable=0; unconditionally → ACCESS, wait counter cleared.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable through SETUP+ACCESS.
  - pready=1: complete; rsp_valid next cycle, rsp_err=pslverr, rsp_rdata=prdata if read && !pslverr else 0. FIFO non-empty → pop, go SETUP (psel stays 1, penable drops); else IDLE.
  - pready=0: counter++; if TIMEOUT≠0 and this is the TIMEOUT-th ACCESS cycle → abort: rsp_valid, rsp_err=1, rsp_rdata=0, next state as on completion.
- Push and pop in same cycle allowed; count unchanged.
- Outputs in IDLE: psel=penable=pwrite=0, paddr=pwdata=0.
- Reset (any time, incl. mid-ACCESS): FIFO emptied, FSM IDLE, all outputs 0 except req_ready=1; in-flight transfer dropped without response.

## Timing
- All outputs registered except req_ready and busy (combinational from registered state).
- Request accepted at edge t into empty FIFO, FSM IDLE: psel=1 in cycle t+2, penable=1 in t+3.
- Zero-wait slave (pready=1 in first ACCESS cycle): rsp_valid in cycle t+4; each transfer occupies 2 APB cycles; N queued writes finish in 2N cycles with psel continuously high.
- Each wait state adds one cycle. Timeout abort: rsp_valid one cycle after the TIMEOUT-th ACCESS cycle.
- rsp_valid high exactly one cycle per transfer; no backpressure.

## Test plan
- Single write mvu_id=2, csr=0x010, data=0xDEAD_BEEF, pready tied 1 → paddr=0x2010, pwrite=1, psel at t+2, penable at t+3, rsp_valid t+4, rsp_err=0.
- Three writes accepted on consecutive cycles → psel high 6 consecutive cycles, penable pattern 0,1,0,1,0,1, three rsp_valid pulses in order, busy drops after last.
- Hold slave pready=0; push 5 requests (FIFO_DEPTH=4, one in flight) → req_ready low after 5th accepted, 6th stalls until first completes.
- Read csr 0x020 with 3 wait states, prdata=0x1234 → ACCESS lasts 4 cycles, rsp_rdata=0x1234, rsp_err=0; then pslverr=1 read → rsp_err=1, rsp_rdata=0.
- TIMEOUT=16, pready never asserted → abort after 16th ACCESS cycle, rsp_err=1, next queued request starts SETUP immediately.
- rst_n low mid-ACCESS → psel/penable 0 asynchronously, no rsp_valid, FIFO empty, req_ready=1, busy=0 after release.
